// File: rtl/rv64_div_unit.sv
// Multi-cycle RV64M DIV/DIVU/REM/REMU (+W) unit, radix-2 restoring, one quotient bit per cycle.
// Latency: out_valid at accept+N+3 (N=64, or 32 for W ops); accept+2 for divide-by-zero/overflow.
// Backpressure: in_ready only in IDLE; result/out_valid held in DONE until out_ready; kill aborts.
// Ports: clk/reset; in_valid/in_ready with operand_a, operand_b, div_op, word_op; kill;
//        out_valid/out_ready with result; busy.
// Build option: DIV_EARLY_OUT_EN skips CALC when |dividend| < |divisor|.
module rv64_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [1:0]      div_op,
    input  logic            word_op,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] a_q, a_d, b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic        word_q, word_d;
    logic [63:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] result_q, result_d;

    // Operand conditioning, evaluated from the latched request (used in PREP).
    logic        sgn, a_neg, b_neg, div_zero, ovf, early;
    logic [63:0] ext_a, ext_b, mag_a, mag_b, min_val;
    logic [64:0] rem_sh, diff;
    logic [63:0] q_fix, r_fix, pick;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    assign sgn      = ~op_q[0];
    assign ext_a    = word_q ? {{32{sgn & a_q[31]}}, a_q[31:0]} : a_q;
    assign ext_b    = word_q ? {{32{sgn & b_q[31]}}, b_q[31:0]} : b_q;
    assign a_neg    = sgn & ext_a[63];
    assign b_neg    = sgn & ext_b[63];
    assign mag_a    = a_neg ? (64'd0 - ext_a) : ext_a;
    assign mag_b    = b_neg ? (64'd0 - ext_b) : ext_b;
    assign min_val  = word_q ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign div_zero = (ext_b == 64'd0);
    assign ovf      = sgn & (ext_a == min_val) & (ext_b == '1);
`ifdef DIV_EARLY_OUT_EN
    assign early    = ~div_zero & (mag_a < mag_b);
`else
    assign early    = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    assign rem_sh = {rem_q, quo_q[63]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    assign q_fix = qneg_q ? (64'd0 - quo_q) : quo_q;
    assign r_fix = rneg_q ? (64'd0 - rem_q) : rem_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        word_d      = word_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        pick        = 64'd0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = operand_a;
                    b_d     = operand_b;
                    op_d    = div_op;
                    word_d  = word_op;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (div_zero || ovf || early) begin
                    // quotient/remainder pair for the short-circuit cases
                    if (div_zero)
                        pick = op_q[1] ? ext_a : '1;
                    else if (ovf)
                        pick = op_q[1] ? 64'd0 : ext_a;
                    else
                        pick = op_q[1] ? ext_a : 64'd0;
                    result_d = word_q ? sext32(pick[31:0]) : pick;
                    state_d  = DONE;
                end else begin
                    rem_d   = 64'd0;
                    // W dividends sit in the top half so the MSB-first shift sees them first.
                    quo_d   = word_q ? {mag_a[31:0], 32'd0} : mag_a;
                    dvs_d   = mag_b;
                    cnt_d   = word_q ? 7'd32 : 7'd64;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (!diff[64]) begin
                    rem_d = diff[63:0];
                    quo_d = {quo_q[62:0], 1'b1};
                end else begin
                    rem_d = rem_sh[63:0];
                    quo_d = {quo_q[62:0], 1'b0};
                end
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1)
                    state_d = FIX;
            end
            FIX: begin
                pick     = op_q[1] ? r_fix : q_fix;
                result_d = word_q ? sext32(pick[31:0]) : pick;
                state_d  = DONE;
            end
            DONE: begin
                // out_valid is registered one cycle after entering DONE.
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over accept and over the output handshake.
        if (kill) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            if (state_q == IDLE) begin
                a_d    = a_q;
                b_d    = b_q;
                op_d   = op_q;
                word_d = word_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            word_q      <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            word_q      <= word_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule

// File: tb/tb_rv64_div_unit.sv
module tb_rv64_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
    logic [1:0]  div_op;
    logic        word_op;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic busy_at1;
    int   lat;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 67;
`endif

    rv64_div_unit #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .div_op(div_op), .word_op(word_op), .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request; returns just after the accepting edge E0.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op, input logic w);
        in_valid  = 1'b1;
        operand_a = a;
        operand_b = b;
        div_op    = op;
        word_op   = w;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    // Counts edges after E0 until out_valid is seen; -1 on timeout.
    task automatic wait_out(output int l);
        l = -1;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) busy_at1 = busy;
            if (out_valid) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] op, input logic w, input int exp_lat, input logic [63:0] exp_res);
        issue(a, b, op, w);
        wait_out(lat);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, result, exp_res);
    endtask

    // With out_ready high the handshake completes on the next edge.
    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        chk({tag, " out_valid drop"}, {63'd0, out_valid}, 64'd0);
        chk({tag, " in_ready back"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; operand_a = '0; operand_b = '0;
        div_op = '0; word_op = 1'b0; kill = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset result", result, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run("DIVU 100/7", 64'd100, 64'd7, OP_DIVU, 1'b0, 67, 64'd14);
        chk("DIVU busy at E0+1", {63'd0, busy_at1}, 64'd1);
        chk("DIVU busy at E0+67", {63'd0, busy}, 64'd1);
        drain("DIVU 100/7");

        run("REM -100/7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, OP_REM, 1'b0, 67, 64'hFFFF_FFFF_FFFF_FFFE);
        drain("REM -100/7");
        run("DIV -100/7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, OP_DIV, 1'b0, 67, 64'hFFFF_FFFF_FFFF_FFF2);
        drain("DIV -100/7");
        run("DIV 100/-7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, OP_DIV, 1'b0, 67, 64'hFFFF_FFFF_FFFF_FFF2);
        drain("DIV 100/-7");
        run("REM 100/-7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, OP_REM, 1'b0, 67, 64'd2);
        drain("REM 100/-7");
        run("DIVU max/16", 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, OP_DIVU, 1'b0, 67, 64'h0FFF_FFFF_FFFF_FFFF);
        drain("DIVU max/16");
        run("REMU max/16", 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, OP_REMU, 1'b0, 67, 64'hF);
        drain("REMU max/16");

        run("DIVW ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_DIV, 1'b1, 2, 64'hFFFF_FFFF_8000_0000);
        drain("DIVW ovf");
        run("REMW ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_REM, 1'b1, 2, 64'd0);
        drain("REMW ovf");
        run("DIV ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, OP_DIV, 1'b0, 2, 64'h8000_0000_0000_0000);
        drain("DIV ovf");
        run("REMUW b=0", 64'h0000_0001_8000_0001, 64'd0, OP_REMU, 1'b1, 2, 64'hFFFF_FFFF_8000_0001);
        drain("REMUW b=0");
        run("REM b=0", 64'hFFFF_FFFF_FFFF_FF9C, 64'd0, OP_REM, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FF9C);
        drain("REM b=0");

        run("DIVUW fffffffe/2", 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, OP_DIVU, 1'b1, 35, 64'h0000_0000_7FFF_FFFF);
        drain("DIVUW fffffffe/2");
        run("DIVUW ffffffff/1", 64'h0000_0000_FFFF_FFFF, 64'd1, OP_DIVU, 1'b1, 35, 64'hFFFF_FFFF_FFFF_FFFF);
        drain("DIVUW ffffffff/1");
        run("REMW -7/2", 64'h0000_0000_FFFF_FFF9, 64'd2, OP_REM, 1'b1, 35, 64'hFFFF_FFFF_FFFF_FFFF);
        drain("REMW -7/2");
        run("DIVW 100/-7", 64'h1234_5678_0000_0064, 64'hFFFF_FFFF_FFFF_FFF9, OP_DIV, 1'b1, 35, 64'hFFFF_FFFF_FFFF_FFF2);
        drain("DIVW 100/-7");

        run("DIVU 3/10", 64'd3, 64'd10, OP_DIVU, 1'b0, EARLY_LAT, 64'd0);
        drain("DIVU 3/10");
        run("REMU 3/10", 64'd3, 64'd10, OP_REMU, 1'b0, EARLY_LAT, 64'd3);
        drain("REMU 3/10");

        // Output held under backpressure.
        out_ready = 1'b0;
        run("DIVU 5/0", 64'd5, 64'd0, OP_DIVU, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("hold out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold result", result, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("hold in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        drain("DIVU 5/0");

        // Kill at E0+10 of a 64-bit DIV, then a fresh request the next cycle.
        issue(64'd1000, 64'd3, OP_DIV, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill busy", {63'd0, busy}, 64'd0);
        chk("kill in_ready", {63'd0, in_ready}, 64'd1);
        chk("kill out_valid", {63'd0, out_valid}, 64'd0);
        run("post-kill DIVU 100/7", 64'd100, 64'd7, OP_DIVU, 1'b0, 67, 64'd14);
        drain("post-kill");

        // Kill has priority over in_valid in IDLE.
        in_valid = 1'b1; kill = 1'b1;
        operand_a = 64'd9; operand_b = 64'd3; div_op = OP_DIVU; word_op = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; kill = 1'b0;
        chk("kill blocks accept", {63'd0, busy}, 64'd0);

        // Kill has priority over the output handshake in DONE.
        run("DIVU 7/0 pre-kill", 64'd7, 64'd0, OP_DIVU, 1'b0, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill in DONE out_valid", {63'd0, out_valid}, 64'd0);
        chk("kill in DONE busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-operation clears everything, including result.
        issue(64'd100, 64'd7, OP_DIVU, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid reset busy", {63'd0, busy}, 64'd0);
        chk("mid reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid reset result", result, 64'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run("post-reset REMU 100/7", 64'd100, 64'd7, OP_REMU, 1'b0, 67, 64'd2);
        drain("post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
